// File: rtl/dds_hop_phase_gen.sv
// Multi-lane DDS phase generator: serial lane-offset load, dwell-timed frequency
// hopping with phase continuity, and pulse gating aligned to the phase stream.
module dds_hop_phase_gen #(
  parameter int LANES = 16,
  parameter int PW    = 32,
  parameter int DW    = 32
) (
  input  logic                clk_user_bufg,
  input  logic                rst_glb,
  input  logic                cfg_load,
  input  logic [1:0]          mode_i,
  input  logic [PW-1:0]       ftw_start_i,
  input  logic [PW-1:0]       ftw_step_i,
  input  logic [PW-1:0]       ftw_stop_i,
  input  logic [DW-1:0]       dwell_i,
  input  logic [DW-1:0]       prt_width_i,
  input  logic [DW-1:0]       prt_cycle_i,
  output logic [LANES*PW-1:0] phase_o,
  output logic                valid_o,
  output logic                gate_o,
  output logic                pulse_user,
  output logic [15:0]         hop_idx_o,
  output logic                busy_o
);

  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(LANES - 1);
  localparam logic [DW-1:0] ONE_DW = 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [PW-1:0] run_sum, ftw, lane_step, acc;
  logic [PW-1:0] offset [LANES];
  logic [1:0]    mode_q;
  logic [PW-1:0] start_q, step_q, stop_q;
  logic [DW-1:0] dwell_q, width_q, cycle_q;
  logic [DW-1:0] dwell_cnt, prt_cnt;
  logic [15:0]   hop_idx;

  logic [DW-1:0] dwell_last;
  logic          dwell_done, hop_en, hop_wrap, prt_wrap, gate;
  logic [PW:0]   hop_sum;

  assign busy_o     = (state == S_LOAD);
  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - ONE_DW;
  assign dwell_done = (dwell_cnt == dwell_last);
  assign hop_en     = mode_q[1] && (step_q != '0);
  // The extra top bit catches tuning words that overflow the accumulator width.
  assign hop_sum    = {1'b0, ftw} + {1'b0, step_q};
  assign hop_wrap   = hop_sum[PW] || (hop_sum[PW-1:0] > stop_q);
  assign prt_wrap   = (cycle_q == '0) || (prt_cnt == cycle_q - ONE_DW);

  // NOTE: assign a default on every path of always_comb so no latch is inferred.
  always_comb begin
    gate = 1'b1;
    if (mode_q[0]) begin
      if (width_q == '0)                               gate = 1'b0;
      else if ((cycle_q == '0) || (width_q >= cycle_q)) gate = 1'b1;
      else                                             gate = (prt_cnt < width_q);
    end
  end

  // NOTE: the offset table is fully rewritten in LOAD before RUN reads it, so it needs no reset.
  always_ff @(posedge clk_user_bufg) begin
    if (state == S_LOAD) offset[k] <= run_sum;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_user_bufg) begin
    if (!rst_glb) begin
      state      <= S_IDLE;
      k          <= '0;
      run_sum    <= '0;
      ftw        <= '0;
      lane_step  <= '0;
      acc        <= '0;
      mode_q     <= '0;
      start_q    <= '0;
      step_q     <= '0;
      stop_q     <= '0;
      dwell_q    <= '0;
      width_q    <= '0;
      cycle_q    <= '0;
      dwell_cnt  <= '0;
      prt_cnt    <= '0;
      hop_idx    <= '0;
      phase_o    <= '0;
      valid_o    <= 1'b0;
      gate_o     <= 1'b0;
      pulse_user <= 1'b0;
      hop_idx_o  <= '0;
    end else if (cfg_load) begin
      mode_q     <= mode_i;
      start_q    <= ftw_start_i;
      step_q     <= ftw_step_i;
      stop_q     <= ftw_stop_i;
      dwell_q    <= dwell_i;
      width_q    <= prt_width_i;
      cycle_q    <= prt_cycle_i;
      ftw        <= ftw_start_i;
      acc        <= '0;
      hop_idx    <= '0;
      dwell_cnt  <= '0;
      prt_cnt    <= '0;
      k          <= '0;
      run_sum    <= '0;
      state      <= S_LOAD;
      valid_o    <= 1'b0;
      gate_o     <= 1'b0;
      pulse_user <= 1'b0;
      hop_idx_o  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          valid_o    <= 1'b0;
          gate_o     <= 1'b0;
          pulse_user <= 1'b0;
          run_sum    <= run_sum + ftw;
          k          <= k + 1'b1;
          if (k == K_LAST) begin
            lane_step <= run_sum + ftw;
            k         <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc + lane_step;
          for (int i = 0; i < LANES; i++) phase_o[i*PW +: PW] <= acc + offset[i];
          valid_o    <= 1'b1;
          gate_o     <= gate;
          pulse_user <= gate && (!gate_o || (prt_cnt == '0));
          hop_idx_o  <= hop_idx;
          prt_cnt    <= prt_wrap ? '0 : prt_cnt + ONE_DW;
          if (hop_en) begin
            if (dwell_done) begin
              dwell_cnt <= '0;
              run_sum   <= '0;
              state     <= S_LOAD;
              if (hop_wrap) begin
                ftw     <= start_q;
                hop_idx <= '0;
              end else begin
                ftw     <= hop_sum[PW-1:0];
                hop_idx <= hop_idx + 16'd1;
              end
            end else begin
              dwell_cnt <= dwell_cnt + ONE_DW;
            end
          end
        end
        default: begin
          valid_o    <= 1'b0;
          gate_o     <= 1'b0;
          pulse_user <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_hop_phase_gen.sv
// Scoreboard bench for dds_hop_phase_gen: expected per-cycle outputs are queued
// alongside each directed step and compared one entry per clock.
module tb_dds_hop_phase_gen;

  localparam int LANES = 16;
  localparam int PW    = 32;
  localparam int DW    = 32;
  localparam int VW    = LANES * PW;

  logic             clk_user_bufg = 1'b0;
  logic             rst_glb = 1'b0;
  logic             cfg_load = 1'b0;
  logic [1:0]       mode_i = '0;
  logic [PW-1:0]    ftw_start_i = '0, ftw_step_i = '0, ftw_stop_i = '0;
  logic [DW-1:0]    dwell_i = '0, prt_width_i = '0, prt_cycle_i = '0;
  logic [VW-1:0]    phase_o;
  logic             valid_o, gate_o, pulse_user, busy_o;
  logic [15:0]      hop_idx_o;

  int    checks = 0;
  int    errors = 0;
  string step_name = "reset";

  typedef struct {
    logic          busy, valid, gate, pulse;
    bit            chk_pulse, chk_hop, chk_ph;
    logic [15:0]   hop;
    logic [VW-1:0] phase;
  } exp_t;

  exp_t sb[$];

  dds_hop_phase_gen #(.LANES(LANES), .PW(PW), .DW(DW)) dut (
    .clk_user_bufg(clk_user_bufg), .rst_glb(rst_glb), .cfg_load(cfg_load),
    .mode_i(mode_i), .ftw_start_i(ftw_start_i), .ftw_step_i(ftw_step_i),
    .ftw_stop_i(ftw_stop_i), .dwell_i(dwell_i), .prt_width_i(prt_width_i),
    .prt_cycle_i(prt_cycle_i), .phase_o(phase_o), .valid_o(valid_o),
    .gate_o(gate_o), .pulse_user(pulse_user), .hop_idx_o(hop_idx_o), .busy_o(busy_o)
  );

  always #5 clk_user_bufg = ~clk_user_bufg;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s %s: observed %0h expected %0h", step_name, tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] lanes_of(input logic [PW-1:0] a, input logic [PW-1:0] f);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*PW +: PW] = a + PW'(i) * f;
    return v;
  endfunction

  task automatic push_gap(input int n, input logic busy);
    exp_t e;
    e = '{busy: busy, valid: 1'b0, gate: 1'b0, pulse: 1'b0, chk_pulse: 1'b1,
          chk_hop: 1'b0, chk_ph: 1'b0, hop: '0, phase: '0};
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic push_reset(input int n);
    exp_t e;
    e = '{busy: 1'b0, valid: 1'b0, gate: 1'b0, pulse: 1'b0, chk_pulse: 1'b1,
          chk_hop: 1'b1, chk_ph: 1'b1, hop: '0, phase: '0};
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic push_startup();
    push_gap(LANES, 1'b1);
    push_gap(1, 1'b0);
  endtask

  task automatic push_word(input logic [PW-1:0] a, input logic [PW-1:0] f, input logic gate,
                           input logic pulse, input bit chk_pulse, input logic [15:0] hop,
                           input logic busy);
    exp_t e;
    e = '{busy: busy, valid: 1'b1, gate: gate, pulse: pulse, chk_pulse: chk_pulse,
          chk_hop: 1'b1, chk_ph: 1'b1, hop: hop, phase: lanes_of(a, f)};
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk_user_bufg);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("busy_o", busy_o, e.busy);
      check("valid_o", valid_o, e.valid);
      check("gate_o", gate_o, e.gate);
      if (e.chk_pulse) check("pulse_user", pulse_user, e.pulse);
      if (e.chk_hop)   check("hop_idx_o", hop_idx_o, e.hop);
      if (e.chk_ph)    check("phase_o", phase_o, e.phase);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) tick();
  endtask

  task automatic strobe();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [PW-1:0] start, input logic [PW-1:0] step,
                         input logic [PW-1:0] stop, input logic [DW-1:0] dwell,
                         input logic [DW-1:0] width, input logic [DW-1:0] cycle);
    mode_i = m; ftw_start_i = start; ftw_step_i = step; ftw_stop_i = stop;
    dwell_i = dwell; prt_width_i = width; prt_cycle_i = cycle;
  endtask

  initial begin
    logic [PW-1:0] acc, f;
    logic [PW-1:0] hop_ftw [4];
    logic [15:0]   hop_id [4];
    logic          g;
    int            cnt;

    // Reset, then idle with reset released.
    push_reset(3);
    drain();
    rst_glb = 1'b1;
    push_reset(2);
    drain();

    // CW start-up, lane offsets, per-word advance and 17th-word wrap.
    step_name = "cw";
    set_cfg(2'd0, 32'h0100_0000, '0, '0, '0, '0, '0);
    push_startup();
    acc = '0;
    for (int j = 0; j < 18; j++) begin
      push_word(acc, 32'h0100_0000, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      acc = acc + PW'(LANES) * 32'h0100_0000;
    end
    strobe();
    drain();

    // Pulsed: width 3, period 10.
    step_name = "pulse_3_10";
    f = 32'h0012_3456;
    set_cfg(2'd1, f, '0, '0, '0, 32'd3, 32'd10);
    push_startup();
    acc = '0;
    for (int j = 0; j < 25; j++) begin
      push_word(acc, f, (j % 10) < 3, (j % 10) == 0, 1'b1, 16'd0, 1'b0);
      acc = acc + PW'(LANES) * f;
    end
    strobe();
    drain();

    // Width equal to period: constantly gated, pulse marker once per period.
    step_name = "pulse_10_10";
    set_cfg(2'd1, f, '0, '0, '0, 32'd10, 32'd10);
    push_startup();
    acc = '0;
    for (int j = 0; j < 22; j++) begin
      push_word(acc, f, 1'b1, (j % 10) == 0, 1'b1, 16'd0, 1'b0);
      acc = acc + PW'(LANES) * f;
    end
    strobe();
    drain();

    // Zero width: never gated.
    step_name = "pulse_0_10";
    set_cfg(2'd1, f, '0, '0, '0, 32'd0, 32'd10);
    push_startup();
    acc = '0;
    for (int j = 0; j < 5; j++) begin
      push_word(acc, f, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0);
      acc = acc + PW'(LANES) * f;
    end
    strobe();
    drain();

    // Zero period: always gated.
    step_name = "pulse_5_0";
    set_cfg(2'd1, f, '0, '0, '0, 32'd5, 32'd0);
    push_startup();
    acc = '0;
    for (int j = 0; j < 5; j++) begin
      push_word(acc, f, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      acc = acc + PW'(LANES) * f;
    end
    strobe();
    drain();

    // Hop sequence with phase continuity across each reload.
    step_name = "hop";
    hop_ftw = '{32'h1000, 32'h2000, 32'h3000, 32'h1000};
    hop_id  = '{16'd0, 16'd1, 16'd2, 16'd0};
    set_cfg(2'd2, 32'h1000, 32'h1000, 32'h3000, 32'd5, '0, '0);
    push_startup();
    acc = '0;
    for (int h = 0; h < 4; h++) begin
      for (int j = 0; j < 5; j++) begin
        push_word(acc, hop_ftw[h], 1'b1, 1'b0, 1'b0, hop_id[h], j == 4);
        acc = acc + PW'(LANES) * hop_ftw[h];
      end
      push_gap(LANES - 1, 1'b1);
      push_gap(1, 1'b0);
    end
    strobe();
    drain();

    // Hop carry-out wraps to start; dwell 0 behaves as dwell 1.
    step_name = "hop_overflow";
    f = 32'hFFFF_F000;
    set_cfg(2'd2, f, 32'h2000, 32'hFFFF_FFFF, 32'd0, '0, '0);
    push_startup();
    acc = '0;
    for (int h = 0; h < 3; h++) begin
      push_word(acc, f, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
      acc = acc + PW'(LANES) * f;
      push_gap(LANES - 1, 1'b1);
      push_gap(1, 1'b0);
    end
    strobe();
    drain();

    // Second cfg_load partway through LOAD restarts the start-up sequence.
    step_name = "cfg_mid_load";
    set_cfg(2'd0, 32'h00AB_CDEF, '0, '0, '0, '0, '0);
    push_gap(7, 1'b1);
    strobe();
    drain();
    f = 32'h0000_0777;
    set_cfg(2'd0, f, '0, '0, '0, '0, '0);
    push_startup();
    acc = '0;
    for (int j = 0; j < 3; j++) begin
      push_word(acc, f, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      acc = acc + PW'(LANES) * f;
    end
    strobe();
    drain();

    // Pulsed run interrupted by reset mid-pulse.
    step_name = "reset_mid_run";
    f = 32'h0101_0101;
    set_cfg(2'd1, f, '0, '0, '0, 32'd4, 32'd8);
    push_startup();
    acc = '0;
    for (int j = 0; j < 10; j++) begin
      push_word(acc, f, (j % 8) < 4, (j % 8) == 0, 1'b1, 16'd0, 1'b0);
      acc = acc + PW'(LANES) * f;
    end
    strobe();
    drain();
    rst_glb = 1'b0;
    push_reset(1);
    tick();
    rst_glb = 1'b1;
    push_reset(6);
    drain();

    // cfg_load together with reset: reset wins and the block stays idle.
    step_name = "reset_vs_cfg";
    rst_glb  = 1'b0;
    cfg_load = 1'b1;
    push_reset(1);
    tick();
    rst_glb  = 1'b1;
    cfg_load = 1'b0;
    push_reset(4);
    drain();

    // Pulsed hop: PRT counter holds through LOAD.
    step_name = "pulsed_hop";
    f = 32'h0000_0100;
    set_cfg(2'd3, f, 32'h100, 32'h100, 32'd3, 32'd2, 32'd4);
    push_startup();
    acc = '0;
    cnt = 0;
    for (int h = 0; h < 3; h++) begin
      for (int j = 0; j < 3; j++) begin
        g = (cnt % 4) < 2;
        push_word(acc, f, g, g && ((cnt % 4) == 0 || j == 0), 1'b1, 16'd0, j == 2);
        acc = acc + PW'(LANES) * f;
        cnt++;
      end
      push_gap(LANES - 1, 1'b1);
      push_gap(1, 1'b0);
    end
    strobe();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
